// File: rtl/ia_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ia_fetch_pkg
// Shared definitions for the input-activation address and fetch stages:
// default array geometry, coordinate field width and the fetch FSM states.
// ---------------------------------------------------------------------------
package ia_fetch_pkg;

  localparam int DEF_W_C_LENGTH  = 16;  // coordinate entries in the RF array
  localparam int DEF_IA_ROW      = 16;  // input-activation rows
  localparam int DEF_IA_COL      = 16;  // input-activation columns
  localparam int DEF_IA_CH       = 8;   // input-activation channels
  localparam int DEF_IA_BITWIDTH = 8;   // activation data width

  // Width of each coordinate field (row / col / ch) in an RF entry.
  localparam int COORD_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ia_addr_calc.sv
// ---------------------------------------------------------------------------
// ia_addr_calc
// Combinational address generator and range check for one RF coordinate.
// Layout in the IA SRAM is channel-major, then row, then column.
//   i_row, i_col, i_ch : coordinate fields of the current entry
//   o_addr             : (ch*IA_ROW + row)*IA_COL + col
//   o_in_range         : 1 when all three fields are inside the tensor
// ---------------------------------------------------------------------------
module ia_addr_calc
  import ia_fetch_pkg::*;
#(
  parameter int IA_ROW = DEF_IA_ROW,
  parameter int IA_COL = DEF_IA_COL,
  parameter int IA_CH  = DEF_IA_CH,
  parameter int ADDR_W = $clog2(IA_ROW * IA_COL * IA_CH)
) (
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  input  logic [COORD_W-1:0] i_ch,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_in_range
);

  always_comb begin
    o_in_range = (int'(i_row) < IA_ROW) && (int'(i_col) < IA_COL) &&
                 (int'(i_ch) < IA_CH);
    // Every in-range address fits in ADDR_W bits, so doing the arithmetic at
    // that width is exact; out-of-range results are never used.
    o_addr = (ADDR_W'(i_ch) * ADDR_W'(IA_ROW) + ADDR_W'(i_row)) * ADDR_W'(IA_COL)
           + ADDR_W'(i_col);
  end

endmodule

// File: rtl/ia_fetch.sv
// ---------------------------------------------------------------------------
// ia_fetch
// Walks the first i_length coordinate entries of i_RF, reads each in-range
// activation from the IA SRAM (zero padding for out-of-range entries) and
// presents it on a valid/ready output channel tagged with its entry index.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_start             : one-cycle start pulse (ignored while busy)
//   i_RF, i_length      : coordinate entries and number of valid entries
//   o_sram_rd/addr      : SRAM read request; i_sram_data returns 1 cycle later
//   o_valid/i_ready     : output handshake carrying o_data and o_idx
//   o_busy, o_done      : transfer in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module ia_fetch
  import ia_fetch_pkg::*;
#(
  parameter  int W_C_LENGTH  = DEF_W_C_LENGTH,
  parameter  int IA_ROW      = DEF_IA_ROW,
  parameter  int IA_COL      = DEF_IA_COL,
  parameter  int IA_CH       = DEF_IA_CH,
  parameter  int IA_BITWIDTH = DEF_IA_BITWIDTH,
  localparam int ADDR_W      = $clog2(IA_ROW * IA_COL * IA_CH),
  localparam int LEN_W       = $clog2(W_C_LENGTH) + 1,
  localparam int IDX_W       = $clog2(W_C_LENGTH)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic [W_C_LENGTH-1:0][2:0][COORD_W-1:0] i_RF,
  input  logic [LEN_W-1:0]                      i_length,
  output logic                                  o_sram_rd,
  output logic [ADDR_W-1:0]                     o_sram_addr,
  input  logic [IA_BITWIDTH-1:0]                i_sram_data,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [IA_BITWIDTH-1:0]                o_data,
  output logic [IDX_W-1:0]                      o_idx,
  output logic                                  o_busy,
  output logic                                  o_done
);

  fetch_state_e            state_q, state_d;
  logic [LEN_W-1:0]        len_q,   len_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;
  logic [IA_BITWIDTH-1:0]  data_q,  data_d;
  logic [ADDR_W-1:0]       addr_q,  addr_d;

  logic                    sram_rd;
  logic [ADDR_W-1:0]       calc_addr;
  logic                    in_range;

  // The upstream stage holds i_RF stable while busy, so the current entry is
  // taken straight from the port rather than copied at start.
  ia_addr_calc #(
    .IA_ROW (IA_ROW),
    .IA_COL (IA_COL),
    .IA_CH  (IA_CH),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .i_row      (i_RF[idx_q][2]),
    .i_col      (i_RF[idx_q][1]),
    .i_ch       (i_RF[idx_q][0]),
    .o_addr     (calc_addr),
    .o_in_range (in_range)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    sram_rd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d   = (i_length > LEN_W'(W_C_LENGTH)) ? LEN_W'(W_C_LENGTH) : i_length;
          idx_d   = '0;
          state_d = (i_length == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (in_range) begin
          sram_rd = 1'b1;
          addr_d  = calc_addr;
          state_d = ST_WAIT;
        end else begin
          data_d  = '0;  // zero padding, no SRAM access
          state_d = ST_OUT;
        end
      end
      ST_WAIT: begin
        data_d  = i_sram_data;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = (LEN_W'(idx_q) + LEN_W'(1) < len_q) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the reset is asynchronous so an abort takes effect immediately,
  // without waiting for the next clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from the
      // values present before the edge.
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // The read is issued in the ISSUE cycle itself so the data returns during
  // WAIT; the registered copy keeps the address steady between reads.
  assign o_sram_rd   = sram_rd;
  assign o_sram_addr = sram_rd ? calc_addr : addr_q;
  assign o_valid     = (state_q == ST_OUT);
  assign o_data      = data_q;
  assign o_idx       = idx_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ia_fetch.sv
// ---------------------------------------------------------------------------
// tb_ia_fetch
// Self-checking bench for ia_fetch. A transfer-level model turns the RF
// contents and length into the expected SRAM read addresses and the expected
// (index, data) output stream; a monitor compares the DUT against it every
// cycle. Directed scenarios pin latencies and literal values.
// ---------------------------------------------------------------------------
module tb_ia_fetch;
  import ia_fetch_pkg::*;

  localparam int NE = 16;
  localparam int AW = 11;
  localparam int LW = 5;
  localparam int IW = 4;
  localparam int DW = 8;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        i_start = 1'b0;
  logic                        i_ready = 1'b1;
  logic [NE-1:0][2:0][6:0]     rf = '0;
  logic [LW-1:0]               i_length = '0;
  logic [DW-1:0]               sram_q = '0;
  logic                        o_sram_rd;
  logic [AW-1:0]               o_sram_addr;
  logic                        o_valid;
  logic [DW-1:0]               o_data;
  logic [IW-1:0]               o_idx;
  logic                        o_busy;
  logic                        o_done;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_count = 0;
  int ready_mode = 0;  // 0: ready high, 1: random, 2: ready low
  int last_addr = 0;
  int exp_rd[$];
  int exp_idx[$];
  int exp_data[$];

  always #5 clk = ~clk;

  ia_fetch dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_RF        (rf),
    .i_length    (i_length),
    .o_sram_rd   (o_sram_rd),
    .o_sram_addr (o_sram_addr),
    .i_sram_data (sram_q),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_idx       (o_idx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: data = addr[7:0] one cycle after a read, noise otherwise.
  initial forever begin
    @(posedge clk);
    sram_q <= o_sram_rd ? o_sram_addr[7:0] : 8'($urandom);
  end

  // Ready driver, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: compares the DUT against the expected streams every cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_rd.delete();
      exp_idx.delete();
      exp_data.delete();
      last_addr = 0;
    end else begin
      if (o_sram_rd) begin
        check("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) check("rd_addr", o_sram_addr, exp_rd.pop_front());
        last_addr = int'(o_sram_addr);
      end else begin
        check("addr_hold", o_sram_addr, last_addr);
      end
      if (o_valid) begin
        check("valid_expected", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) begin
          check("o_idx", o_idx, exp_idx[0]);
          check("o_data", o_data, exp_data[0]);
          if (i_ready) begin
            void'(exp_idx.pop_front());
            void'(exp_data.pop_front());
          end
        end
        if (i_ready) hs_count++;
      end
      if (o_done) begin
        done_count++;
        check("done_after_all", exp_data.size() + exp_rd.size(), 0);
      end
      if (o_sram_rd || o_valid || o_done) check("busy_active", o_busy, 1);
    end
  end

  // Transfer model: what a fetch of the current RF and length must produce.
  task automatic load_model();
    int n;
    int row, col, ch, a;
    n = (int'(i_length) > NE) ? NE : int'(i_length);
    for (int i = 0; i < n; i++) begin
      row = int'(rf[i][2]);
      col = int'(rf[i][1]);
      ch  = int'(rf[i][0]);
      if (row < 16 && col < 16 && ch < 8) begin
        a = (ch * 16 + row) * 16 + col;
        exp_rd.push_back(a);
        exp_data.push_back(a % 256);
      end else begin
        exp_data.push_back(0);
      end
      exp_idx.push_back(i);
    end
  endtask

  task automatic set_entry(input int i, input int r, input int c, input int ch);
    rf[i][2] = 7'(r);
    rf[i][1] = 7'(c);
    rf[i][0] = 7'(ch);
  endtask

  function automatic int pick(input int lim);
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(lim, 127));
    return int'($urandom_range(0, lim - 1));
  endfunction

  task automatic rand_entries(input bit all_in_range);
    for (int i = 0; i < NE; i++) begin
      if (all_in_range)
        set_entry(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      else
        set_entry(i, pick(16), pick(16), pick(8));
    end
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Waits for o_done; optionally pokes i_start/i_length while busy.
  task automatic wait_done(input int bound, input bit inject);
    bit got = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) begin
        got = 1'b1;
        break;
      end
      if (inject && o_busy && $urandom_range(0, 7) == 0) begin
        i_start  = 1'b1;
        i_length = LW'($urandom);
      end
    end
    i_start = 1'b0;
    check("done_seen", got, 1);
  endtask

  task automatic wait_valid(input int want);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_valid && int'(o_idx) == want) begin
        got = 1'b1;
        break;
      end
    end
    check("valid_seen", got, 1);
  endtask

  task automatic run_transfer(input int len, input bit inject);
    i_length = LW'(len);
    load_model();
    start_pulse();
    wait_done(3000, inject);
    @(negedge clk);
    check("idle_after_done", o_busy, 0);
    check("stream_drained", exp_data.size() + exp_rd.size(), 0);
  endtask

  initial begin
    int d0, h0, hs, held_data, held_idx;
    bit got;

    // Reset state.
    #3;
    check("rst_rd", o_sram_rd, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_addr", o_sram_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_idx", o_idx, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single in-range entry: (row 2, col 3, ch 1) -> address 291, data 0x23.
    ready_mode = 0;
    set_entry(0, 2, 3, 1);
    i_length = LW'(1);
    load_model();
    d0 = done_count;
    start_pulse();
    @(negedge clk);
    check("t1_rd_c1", o_sram_rd, 1);
    check("t1_addr_c1", o_sram_addr, 291);
    @(negedge clk);
    check("t1_rd_c2", o_sram_rd, 0);
    check("t1_valid_c2", o_valid, 0);
    @(negedge clk);
    check("t1_valid_c3", o_valid, 1);
    check("t1_data", o_data, 8'h23);
    check("t1_idx", o_idx, 0);
    wait_done(50, 1'b0);
    @(negedge clk);
    check("t1_done_count", done_count - d0, 1);

    // Out-of-range entry 0 is padded without a read; entry 1 reads 17.
    set_entry(0, 16, 0, 0);
    set_entry(1, 1, 1, 0);
    i_length = LW'(2);
    load_model();
    start_pulse();
    @(negedge clk);
    check("t2_no_rd_c1", o_sram_rd, 0);
    @(negedge clk);
    check("t2_valid_c2", o_valid, 1);
    check("t2_pad_data", o_data, 0);
    check("t2_idx0", o_idx, 0);
    @(negedge clk);
    check("t2_rd_c3", o_sram_rd, 1);
    check("t2_addr_c3", o_sram_addr, 17);
    wait_done(50, 1'b0);

    // Backpressure: ready held low for 5 cycles while entry 1 is offered.
    set_entry(0, 5, 6, 2);
    set_entry(1, 7, 8, 3);
    set_entry(2, 0, 15, 7);
    i_length = LW'(3);
    load_model();
    d0 = done_count;
    h0 = hs_count;
    ready_mode = 2;
    start_pulse();
    wait_valid(0);
    ready_mode = 0;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!o_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("t3_first_hs", got, 1);
    ready_mode = 2;
    wait_valid(1);
    held_data = int'(o_data);
    held_idx  = int'(o_idx);
    check("t3_held_data_value", held_data, ((3 * 16 + 7) * 16 + 8) % 256);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t3_valid_held", o_valid, 1);
      check("t3_data_stable", o_data, held_data);
      check("t3_idx_stable", o_idx, held_idx);
    end
    ready_mode = 0;
    wait_done(50, 1'b0);
    @(negedge clk);
    check("t3_handshakes", hs_count - h0, 3);
    check("t3_done_count", done_count - d0, 1);

    // Zero length, with i_start held into the DONE cycle.
    i_length = '0;
    load_model();
    d0 = done_count;
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_done_c1", o_done, 1);
    check("t4_no_rd", o_sram_rd, 0);
    check("t4_no_valid", o_valid, 0);
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t4_quiet_rd", o_sram_rd, 0);
      check("t4_quiet_valid", o_valid, 0);
    end
    check("t4_done_count", done_count - d0, 1);

    // Reset after the 4th handshake of a 10-entry transfer.
    rand_entries(1'b1);
    i_length = LW'(10);
    load_model();
    start_pulse();
    hs = 0;
    for (int n = 0; n < 200 && hs < 4; n++) begin
      @(negedge clk);
      if (o_valid && i_ready) hs++;
    end
    check("t5_reached_4hs", hs, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rd", o_sram_rd, 0);
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_done", o_done, 0);
    check("t5_rst_addr", o_sram_addr, 0);
    check("t5_rst_data", o_data, 0);
    check("t5_rst_idx", o_idx, 0);
    d0 = done_count;
    for (int n = 0; n < 3; n++) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t5_no_activity", o_sram_rd || o_valid || o_done, 0);
    end
    check("t5_no_done", done_count - d0, 0);
    d0 = done_count;
    h0 = hs_count;
    run_transfer(10, 1'b0);
    check("t5_restart_hs", hs_count - h0, 10);
    check("t5_restart_done", done_count - d0, 1);

    // Randomized transfers with random backpressure and ignored restarts.
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      rand_entries(1'b0);
      if (t == 0)      run_transfer(16, 1'b1);
      else if (t == 1) run_transfer(31, 1'b1);
      else             run_transfer($urandom_range(0, 20), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
